// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and data-memory wait with timeout.
// Optional stall-cycle counter port stall_count is built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] IF_ID_Rs1,
   input  logic [4:0] IF_ID_Rs2,
   input  logic       ID_uses_rs1,
   input  logic       ID_uses_rs2,
   input  logic [4:0] ID_EX_Rd,
   input  logic       ID_EX_MemRead,
   input  logic       EX_branch_taken,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       IF_ID_write,
   output logic       IF_ID_flush,
   output logic       ID_EX_write,
   output logic       ID_EX_bubble,
   output logic       EX_MEM_write,
   output logic       mem_error
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_count
`endif
);

   localparam int WCW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] TIMEOUT_V  = WCW'(MEM_TIMEOUT);
   localparam logic [WCW-1:0] TIMEOUT_M1 = WCW'(MEM_TIMEOUT - 1);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t         state, state_nxt;
   logic [WCW-1:0] wait_cnt;
   logic           freeze;
   logic           load_use;
   logic           lu_stall;

   assign load_use = ID_EX_MemRead && (ID_EX_Rd != 5'd0) &&
                     ((ID_uses_rs1 && (ID_EX_Rd == IF_ID_Rs1)) ||
                      (ID_uses_rs2 && (ID_EX_Rd == IF_ID_Rs2)));

   // A frozen pipeline keeps the branch/load in EX, so deferred hazards
   // reappear on the inputs in the release cycle without extra state.
   always_comb begin
      state_nxt    = state;
      freeze       = 1'b0;
      lu_stall     = 1'b0;
      pc_write     = 1'b1;
      IF_ID_write  = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_write  = 1'b1;
      ID_EX_bubble = 1'b0;
      EX_MEM_write = 1'b1;
      case (state)
         RUN: begin
            if (mem_req && !mem_ready) begin
               freeze    = 1'b1;
               state_nxt = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) state_nxt = RUN;
            else           freeze    = 1'b1;
         end
         default: state_nxt = RUN;
      endcase
      if (freeze) begin
         pc_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_write  = 1'b0;
         EX_MEM_write = 1'b0;
      end else if (EX_branch_taken) begin
         IF_ID_flush  = 1'b1;
         ID_EX_bubble = 1'b1;
      end else if (load_use) begin
         lu_stall     = 1'b1;
         pc_write     = 1'b0;
         IF_ID_write  = 1'b0;
         ID_EX_bubble = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN;
         wait_cnt  <= '0;
         mem_error <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == MEM_WAIT) begin
            if (wait_cnt != TIMEOUT_V) wait_cnt <= wait_cnt + 1'b1;
            // Flag on the edge where the count reaches the timeout; waiting continues.
            if (wait_cnt >= TIMEOUT_M1) mem_error <= 1'b1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_count <= '0;
      else if ((freeze || lu_stall) && (stall_count != {CNT_W{1'b1}}))
         stall_count <= stall_count + 1'b1;
   end
`else
   // lu_stall only feeds the optional counter.
   logic unused_lu;
   assign unused_lu = lu_stall;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit (MEM_TIMEOUT reduced to 4).
module tb_hazard_stall_unit;

   localparam int CNT_W = 32;
   // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_write}
   localparam logic [5:0] IDLE   = 6'b110101;
   localparam logic [5:0] FRZ    = 6'b000000;
   localparam logic [5:0] BRANCH = 6'b111111;
   localparam logic [5:0] LDUSE  = 6'b000111;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [4:0] IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
   logic ID_uses_rs1, ID_uses_rs2, ID_EX_MemRead, EX_branch_taken, mem_req, mem_ready;
   logic pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_write, mem_error;
   logic [CNT_W-1:0] stall_count;
   logic [5:0] ctl;

   int checks = 0;
   int fails  = 0;

   assign ctl = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_write};

   always #5 clk = ~clk;

   hazard_stall_unit #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2),
      .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
      .ID_EX_Rd(ID_EX_Rd), .ID_EX_MemRead(ID_EX_MemRead),
      .EX_branch_taken(EX_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
      .ID_EX_write(ID_EX_write), .ID_EX_bubble(ID_EX_bubble), .EX_MEM_write(EX_MEM_write),
      .mem_error(mem_error)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_count(stall_count)
`endif
   );

`ifndef HAZARD_PERF_CNT_EN
   assign stall_count = '0;
`endif

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic br, input logic req, input logic rdy);
      IF_ID_Rs1 = rs1; IF_ID_Rs2 = rs2; ID_uses_rs1 = u1; ID_uses_rs2 = u2;
      ID_EX_Rd = rd; ID_EX_MemRead = mr; EX_branch_taken = br;
      mem_req = req; mem_ready = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      checks++;
      if (ctl !== IDLE) begin fails++; $display("FAIL reset_ctl got=%b exp=%b", ctl, IDLE); end
      checks++;
      if (mem_error !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", mem_error); end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_count !== '0) begin fails++; $display("FAIL reset_cnt got=%0d exp=0", stall_count); end
`endif
      #2;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_load_use();
      do_reset();
      drive(5, 0, 1, 0, 5, 1, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (ctl !== LDUSE) begin fails++; $display("FAIL lu_rs1 got=%b exp=%b", ctl, LDUSE); end
      step();
      // bubble reached EX: MemRead gone
      drive(5, 0, 1, 0, 5, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (ctl !== IDLE) begin fails++; $display("FAIL lu_after_bubble got=%b exp=%b", ctl, IDLE); end
      step();
      drive(0, 0, 1, 1, 0, 1, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (ctl !== IDLE) begin fails++; $display("FAIL lu_x0 got=%b exp=%b", ctl, IDLE); end
      step();
      drive(5, 0, 0, 0, 5, 1, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (ctl !== IDLE) begin fails++; $display("FAIL lu_unused_rs1 got=%b exp=%b", ctl, IDLE); end
      step();
      drive(3, 9, 0, 1, 9, 1, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (ctl !== LDUSE) begin fails++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, LDUSE); end
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_count !== 32'd2) begin fails++; $display("FAIL lu_count got=%0d exp=2", stall_count); end
`endif
      step();
   endtask

   task automatic test_branch_priority();
      do_reset();
      drive(5, 0, 1, 0, 5, 1, 1, 0, 0);
      @(negedge clk);
      checks++;
      if (ctl !== BRANCH) begin fails++; $display("FAIL br_over_lu got=%b exp=%b", ctl, BRANCH); end
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_count !== '0) begin fails++; $display("FAIL br_not_counted got=%0d exp=0", stall_count); end
`endif
      step();
   endtask

   task automatic test_mem_wait();
      logic [5:0] exp_seq [4];
      do_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
      @(negedge clk);
      checks++;
      if (ctl !== IDLE) begin fails++; $display("FAIL mem_ready_hit got=%b exp=%b", ctl, IDLE); end
      step();
      exp_seq = '{FRZ, FRZ, FRZ, IDLE};
      for (int i = 0; i < 4; i++) begin
         // cycle 2 drops mem_req: MEM_WAIT state must keep the freeze
         drive(0, 0, 0, 0, 0, 0, 0, (i == 1) ? 1'b0 : 1'b1, (i == 3) ? 1'b1 : 1'b0);
         @(negedge clk);
         checks++;
         if (ctl !== exp_seq[i])
            begin fails++; $display("FAIL mem_wait_c%0d got=%b exp=%b", i + 1, ctl, exp_seq[i]); end
         step();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (ctl !== IDLE) begin fails++; $display("FAIL mem_back_run got=%b exp=%b", ctl, IDLE); end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_count !== 32'd3) begin fails++; $display("FAIL mem_count got=%0d exp=3", stall_count); end
`endif
      step();
   endtask

   task automatic test_freeze_branch();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
         @(negedge clk);
         checks++;
         if (ctl !== FRZ) begin fails++; $display("FAIL frz_br_c%0d got=%b exp=%b", i + 1, ctl, FRZ); end
         step();
      end
      drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
      @(negedge clk);
      checks++;
      if (ctl !== BRANCH) begin fails++; $display("FAIL frz_br_release got=%b exp=%b", ctl, BRANCH); end
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (ctl !== IDLE) begin fails++; $display("FAIL frz_br_idle got=%b exp=%b", ctl, IDLE); end
      step();
   endtask

   task automatic test_timeout();
      do_reset();
      // cycle 1 is RUN, cycles 2..5 are wait cycles 1..4
      for (int i = 1; i <= 6; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
         @(negedge clk);
         if (i == 5) begin
            checks++;
            if (mem_error !== 1'b0) begin fails++; $display("FAIL to_early got=%b exp=0", mem_error); end
         end
         if (i == 6) begin
            checks++;
            if (mem_error !== 1'b1) begin fails++; $display("FAIL to_rise got=%b exp=1", mem_error); end
         end
         step();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
      @(negedge clk);
      checks++;
      if (ctl !== IDLE) begin fails++; $display("FAIL to_release got=%b exp=%b", ctl, IDLE); end
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (mem_error !== 1'b1) begin fails++; $display("FAIL to_sticky got=%b exp=1", mem_error); end
      step();
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_error !== 1'b0) begin fails++; $display("FAIL to_async_clr got=%b exp=0", mem_error); end
      #1;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
         step();
      end
      // now in MEM_WAIT; mem_req=0 still freezes unless state left MEM_WAIT
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (ctl !== FRZ) begin fails++; $display("FAIL rmw_in_wait got=%b exp=%b", ctl, FRZ); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (ctl !== IDLE) begin fails++; $display("FAIL rmw_async got=%b exp=%b", ctl, IDLE); end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_count !== '0) begin fails++; $display("FAIL rmw_cnt got=%0d exp=0", stall_count); end
`endif
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (ctl !== IDLE) begin fails++; $display("FAIL rmw_after got=%b exp=%b", ctl, IDLE); end
      step();
      @(negedge clk);
      checks++;
      if (ctl !== IDLE || mem_error !== 1'b0)
         begin fails++; $display("FAIL rmw_idle got=%b/%b exp=%b/0", ctl, mem_error, IDLE); end
      step();
   endtask

   task automatic test_back_to_back();
      do_reset();
      // load-use, then branch, then a 1-cycle memory stall
      drive(7, 0, 1, 0, 7, 1, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (ctl !== LDUSE) begin fails++; $display("FAIL b2b_lu got=%b exp=%b", ctl, LDUSE); end
      step();
      drive(7, 0, 1, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
      checks++;
      if (ctl !== BRANCH) begin fails++; $display("FAIL b2b_br got=%b exp=%b", ctl, BRANCH); end
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      checks++;
      if (ctl !== FRZ) begin fails++; $display("FAIL b2b_frz got=%b exp=%b", ctl, FRZ); end
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
      @(negedge clk);
      checks++;
      if (ctl !== IDLE) begin fails++; $display("FAIL b2b_rel got=%b exp=%b", ctl, IDLE); end
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (stall_count !== 32'd2) begin fails++; $display("FAIL b2b_cnt got=%0d exp=2", stall_count); end
`endif
      step();
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      test_reset();
      test_load_use();
      test_branch_priority();
      test_mem_wait();
      test_freeze_branch();
      test_timeout();
      test_reset_mid_wait();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller for the five-stage RV32 core: it resolves every hazard that operand forwarding cannot. These are the load-use dependence, the taken-branch control hazard and a data memory that is not ready. It sits beside the forwarding logic and drives the stall, bubble and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. It also holds a small memory-wait state machine with timeout detection.

## Interface
- MEM_TIMEOUT, 16: number of consecutive wait cycles after which `mem_error` is raised.
- CNT_W, 32: width of `stall_count`.

- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- IF_ID_Rs1  in  5  rs1 field of the instruction in ID
- IF_ID_Rs2  in  5  rs2 field of the instruction in ID
- ID_uses_rs1  in  1  the instruction in ID reads rs1
- ID_uses_rs2  in  1  the instruction in ID reads rs2
- ID_EX_Rd  in  5  destination register of the instruction in EX
- ID_EX_MemRead  in  1  the instruction in EX is a load
- EX_branch_taken  in  1  the branch or jump in EX redirects the PC
- mem_req  in  1  the instruction in MEM accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register update enable
- IF_ID_write  out  1  IF/ID register load enable
- IF_ID_flush  out  1  load a NOP into IF/ID
- ID_EX_write  out  1  ID/EX register load enable
- ID_EX_bubble  out  1  load a NOP (all control bits 0) into ID/EX
- EX_MEM_write  out  1  EX/MEM register load enable
- mem_error  out  1  sticky memory-timeout flag
- stall_count  out  CNT_W  stall-cycle counter (exists only under the macro below)

## Operation
- States: RUN and MEM_WAIT. Both are encoded in registered state.
- freeze = (RUN and mem_req and !mem_ready) or (MEM_WAIT and !mem_ready).
- load_use = ID_EX_MemRead and ID_EX_Rd != 0 and ((ID_uses_rs1 and ID_EX_Rd == IF_ID_Rs1) or (ID_uses_rs2 and ID_EX_Rd == IF_ID_Rs2)).
- Priority: freeze, then branch, then load_use.
- freeze:
  - pc_write, IF_ID_write, ID_EX_write and EX_MEM_write are 0.
  - All flush and bubble outputs are 0.
  - A taken branch or a load-use condition present in this cycle is held and acted on once freeze clears.
- Branch (not frozen, EX_branch_taken = 1):
  - pc_write = 1, IF_ID_flush = 1, ID_EX_bubble = 1.
  - The load-use stall is suppressed.
- load_use (not frozen, no branch):
  - pc_write = 0, IF_ID_write = 0, ID_EX_bubble = 1.
  - ID_EX_write = 1, EX_MEM_write = 1.
- Idle: all *_write outputs are 1; flush, bubble and error outputs are 0.
- FSM transitions:
  - RUN to MEM_WAIT when mem_req and !mem_ready.
  - MEM_WAIT to RUN on the first edge where mem_ready = 1. Unfreezing is combinational in that same cycle.
  - mem_req at 1 with mem_ready at 1 in RUN causes no stall.
- wait_cnt:
  - Cleared in RUN.
  - Increments each MEM_WAIT cycle and saturates at MEM_TIMEOUT.
  - When wait_cnt reaches MEM_TIMEOUT, mem_error is set. It stays set until reset. The FSM keeps waiting.
- x0 is never a hazard source. An rs field is ignored when its uses_* bit is 0.

## Timing
- All control outputs are combinational from the inputs and the registered state, with zero latency.
- Asynchronous reset clears state to RUN, wait_cnt to 0, mem_error to 0 and stall_count to 0. With all inputs at 0 during reset, the outputs are the idle values above.
- A reset asserted in MEM_WAIT returns the block to RUN immediately. Outputs follow the inputs on the same cycle.
- A load-use stall lasts exactly 1 cycle, because the bubble clears ID_EX_MemRead.
- A memory stall lasts N cycles for an access whose mem_ready arrives N cycles after mem_req.
- mem_error rises on the edge that ends the MEM_TIMEOUT-th wait cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_count is present.
  - It increments by 1 on each edge where freeze or the load_use stall was asserted, and saturates at all-ones.
  - Branch flush cycles are not counted.
- HAZARD_PERF_CNT_EN undefined: the stall_count port and its register are absent. All other behaviour is identical.

## Test plan
- Load-use: ID_EX_MemRead=1, ID_EX_Rd=5, IF_ID_Rs1=5, ID_uses_rs1=1 -> pc_write=0, IF_ID_write=0, ID_EX_bubble=1 for 1 cycle. Repeat with Rd=0 or ID_uses_rs1=0 -> no stall.
- Branch beats load-use: both conditions in one cycle -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1, IF_ID_write=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> all *_write=0 for 3 cycles, all 1 in the 4th. FSM goes RUN, MEM_WAIT, RUN. stall_count=3.
- Freeze holds a branch: EX_branch_taken=1 during a 2-cycle memory wait -> no flush while frozen, IF_ID_flush=1 in the release cycle.
- Timeout: MEM_TIMEOUT=4, mem_ready held at 0 for 6 cycles -> mem_error=1 after the 4th wait cycle and still 1 after mem_ready and return to RUN. rst_n low clears mem_error immediately.
- Reset mid-wait: rst_n low during MEM_WAIT -> state RUN and counters 0 asynchronously. With mem_req=0 after release, outputs are idle.
